// File: rtl/mux_scan_sequencer.sv
// Scans all four channels of a dual 4:1 mux and commits
// both sections' 4-bit sample words at the end of a scan.
module mux_scan_sequencer #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_abort,
  input  logic       i_1Y,
  input  logic       i_2Y,
  output logic       o_B,
  output logic       o_A,
  output logic       o_1G,
  output logic       o_2G,
  output logic [3:0] o_1Q,
  output logic [3:0] o_2Q,
  output logic       o_busy,
  output logic       o_done
);

  localparam logic [2:0] SETTLE_C = 3'(SETTLE);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t     state;
  state_t     nxt;
  logic [1:0] ch;
  logic [1:0] nch;
  logic [2:0] cnt;
  logic [2:0] ncnt;
  logic [3:0] s1;
  logic [3:0] s2;
  logic [3:0] ns1;
  logic [3:0] ns2;
  logic [3:0] nq1;
  logic [3:0] nq2;
  logic       nbusy;

  // Next state, counters, shadow bits and commit values.
  always_comb begin
    nxt  = state;
    nch  = ch;
    ncnt = cnt;
    ns1  = s1;
    ns2  = s2;
    nq1  = o_1Q;
    nq2  = o_2Q;
    case (state)
      IDLE: begin
        if (i_start && !i_abort) begin
          nxt  = SELECT;
          nch  = 2'd0;
          ncnt = SETTLE_C;
        end
      end
      SELECT: begin
        if (i_abort) begin
          nxt  = IDLE;
          nch  = 2'd0;
          ncnt = 3'd0;
        end else if (cnt == 3'd0) begin
          nxt = SAMPLE;
        end else begin
          ncnt = cnt - 3'd1;
        end
      end
      SAMPLE: begin
        if (i_abort) begin
          nxt  = IDLE;
          nch  = 2'd0;
          ncnt = 3'd0;
        end else begin
          ns1[ch] = i_1Y;
          ns2[ch] = i_2Y;
          if (ch == 2'd3) begin
            nxt  = DONE;
            nch  = 2'd0;
            ncnt = 3'd0;
            nq1  = ns1;
            nq2  = ns2;
          end else begin
            nxt  = SELECT;
            nch  = ch + 2'd1;
            ncnt = SETTLE_C;
          end
        end
      end
      DONE: begin
        nxt = IDLE;
      end
      default: begin
        nxt = IDLE;
      end
    endcase
  end

  assign nbusy = (nxt == SELECT) || (nxt == SAMPLE);

  // State, counters and shadow registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= IDLE;
      ch    <= 2'd0;
      cnt   <= 3'd0;
      s1    <= 4'd0;
      s2    <= 4'd0;
    end else begin
      state <= nxt;
      ch    <= nch;
      cnt   <= ncnt;
      s1    <= ns1;
      s2    <= ns2;
    end
  end

  // Outputs registered from the next-state decode.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_B    <= 1'b0;
      o_A    <= 1'b0;
      o_1G   <= 1'b1;
      o_2G   <= 1'b1;
      o_1Q   <= 4'd0;
      o_2Q   <= 4'd0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
    end else begin
      o_B    <= nbusy & nch[1];
      o_A    <= nbusy & nch[0];
      o_1G   <= ~nbusy;
      o_2G   <= ~nbusy;
      o_1Q   <= nq1;
      o_2Q   <= nq2;
      o_busy <= nbusy;
      o_done <= (nxt == DONE);
    end
  end

endmodule

// File: doc/mux_scan_sequencer.md
MUX_SCAN_SEQUENCER -- requirements
Module: mux_scan_sequencer

Interface
REQ-001 SHALL have parameter SETTLE, default 1, meaning wait cycles between driving a select code and sampling the mux outputs (legal 0..7).
REQ-002 SHALL have port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port i_rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port i_start, input, 1 bit: scan request, honoured only in IDLE.
REQ-005 SHALL have port i_abort, input, 1 bit: terminates a scan in progress.
REQ-006 SHALL have port i_1Y, input, 1 bit: section-1 output of the downstream dual 4:1 mux.
REQ-007 SHALL have port i_2Y, input, 1 bit: section-2 output of the downstream dual 4:1 mux.
REQ-008 SHALL have port o_B, output, 1 bit: mux select MSB, equal to channel counter bit 1.
REQ-009 SHALL have port o_A, output, 1 bit: mux select LSB, equal to channel counter bit 0.
REQ-010 SHALL have port o_1G, output, 1 bit: section-1 strobe, active-low.
REQ-011 SHALL have port o_2G, output, 1 bit: section-2 strobe, active-low.
REQ-012 SHALL have port o_1Q, output, 4 bits: committed section-1 result; bit n is the i_1Y sample for channel n.
REQ-013 SHALL have port o_2Q, output, 4 bits: committed section-2 result; bit n is the i_2Y sample for channel n.
REQ-014 SHALL have port o_busy, output, 1 bit: high in SELECT and SAMPLE.
REQ-015 SHALL have port o_done, output, 1 bit: one-cycle pulse, high only in DONE.
REQ-016 SHALL drive all outputs from registers; no combinational path from any input to any output.

Function
REQ-017 SHALL implement FSM IDLE, SELECT, SAMPLE, DONE with a 2-bit channel counter ch and a 3-bit settle counter cnt.
REQ-018 In IDLE, i_start=1 and i_abort=0 SHALL move to SELECT with ch=0 and cnt=SETTLE; otherwise remain in IDLE.
REQ-019 In SELECT, cnt=0 SHALL move to SAMPLE; otherwise decrement cnt and stay in SELECT.
REQ-020 In SAMPLE, i_1Y SHALL be written to shadow bit S1[ch] and i_2Y to shadow bit S2[ch].
REQ-021 In SAMPLE with ch<3, the FSM SHALL increment ch, reload cnt=SETTLE and return to SELECT.
REQ-022 In SAMPLE with ch=3, the FSM SHALL go to DONE, loading o_1Q from S1 and o_2Q from S2 (current-cycle samples included) on the same edge.
REQ-023 DONE SHALL last exactly one cycle and then go to IDLE unconditionally; i_start during DONE is ignored.
REQ-024 o_1G and o_2G SHALL be 0 in SELECT and SAMPLE and 1 in IDLE and DONE.
REQ-025 o_B/o_A SHALL change only on the SAMPLE->SELECT edge, so select is stable at least SETTLE+1 cycles before each sample.
REQ-026 o_B/o_A SHALL be 00 in IDLE and DONE.
REQ-027 Scan latency SHALL be 4*(SETTLE+2)+1 rising edges from the edge that samples i_start to the edge that raises o_done; this is 13 edges for SETTLE=1.
REQ-028 i_start while busy SHALL be ignored, with no queuing.
REQ-029 i_abort=1 in SELECT or SAMPLE SHALL go to IDLE on the next edge, with strobes high and select 00; o_1Q/o_2Q unchanged and no o_done pulse.
REQ-030 i_abort has no effect in IDLE or DONE; simultaneous i_start and i_abort in IDLE SHALL stay in IDLE.
REQ-031 i_abort and the ch=3 sample in the same SAMPLE cycle: abort SHALL win, with no commit.
REQ-032 The ch counter SHALL never wrap inside a scan; ch=3 always exits to DONE.
REQ-033 For SETTLE=0, each channel SHALL take SELECT 1 cycle + SAMPLE 1 cycle.

Reset
REQ-034 i_rst_n=0 at a rising edge SHALL force IDLE, ch=0, cnt=0, S1=S2=0, o_1Q=o_2Q=0000, o_1G=o_2G=1, o_B=o_A=0, o_busy=0, o_done=0; this applies from any state, including mid-scan.
REQ-035 Reset SHALL take priority over i_start and i_abort.

Verification
REQ-036 Directed: SETTLE=1; mux model with i_1Y=C1[sel], C1=1010b, and i_2Y=C2[sel], C2=0110b; pulse i_start -> o_done on edge 13, o_1Q=1010, o_2Q=0110, select sequence 00,01,10,11 with each code held 3 cycles.
REQ-037 Directed: i_abort during channel 2 of a scan that follows a completed scan with result 1010/0110 -> IDLE next edge, no o_done, o_1Q/o_2Q remain 1010/0110.
REQ-038 Directed: i_rst_n=0 during SAMPLE of ch=1 -> next edge all outputs at reset values, o_1G=o_2G=1.
REQ-039 Directed: i_start held high continuously -> back-to-back scans separated by exactly DONE plus one IDLE cycle; o_done pulses each 1 cycle wide.
REQ-040 Directed: SETTLE=0 -> o_done 9 edges after start; SETTLE=7 -> 37 edges; results correct in both.
REQ-041 Directed: i_start and i_abort both high in IDLE -> o_busy stays 0 and strobes stay high.
